// File: rtl/ascii_to_fix.sv
// ascii_to_fix: parses a decimal ASCII string into a signed Q(INT_W-1).4 fixed-point word.
// Define ASCII_TO_FIX_ROUND_EN to round the fraction to nearest instead of truncating.
module ascii_to_fix #(
  parameter int INT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [INT_W+3:0] o_fix,
  output logic             o_err,
  output logic             o_ovf,
  output logic             o_valid,
  input  logic             i_ready
);
  localparam int IW = INT_W - 1;  // integer magnitude bits (sign handled separately)
  localparam int MW = IW + 4;     // magnitude width including 4 fraction bits

  typedef enum logic [2:0] {S_IDLE, S_INT, S_FRAC, S_ERR, S_PAD, S_CONV, S_OUT} state_t;
  state_t state, state_nxt;

  logic          neg, ovf, has_dig;
  logic [IW-1:0] int_acc;
  logic [13:0]   d_acc;
  logic [2:0]    n_cnt;
  logic          is_dig, is_minus, is_dot, is_term, take;
  logic [3:0]    dig;
  logic [IW+3:0] int_mul;
  logic [13:0]   d_mul;
  logic [3:0]    frac;
  logic [IW-1:0] int_c;
  logic          ovf_c;
  logic [MW-1:0] mag;
  logic [MW:0]   fix_c;

  assign is_dig   = (i_data >= 8'h30) && (i_data <= 8'h39);
  assign is_minus = (i_data == 8'h2D);
  assign is_dot   = (i_data == 8'h2E);
  assign is_term  = i_data inside {8'h0D, 8'h0A, 8'h20, 8'h00};
  assign dig      = i_data[3:0];
  assign o_ready  = !rst && (state inside {S_IDLE, S_INT, S_FRAC, S_ERR});
  assign take     = i_valid && o_ready;
  assign int_mul  = {4'b0, int_acc} * {{IW{1'b0}}, 4'd10} + {{IW{1'b0}}, dig};
  assign d_mul    = d_acc * 14'd10;

  // D holds the fraction scaled to 4 decimal digits, so each 1/16 step is 625
`ifdef ASCII_TO_FIX_ROUND_EN
  logic [14:0] d_rnd;
  logic [4:0]  q;
  logic [IW:0] int_inc;
  always_comb begin
    d_rnd = {1'b0, d_acc} + 15'd312;
    q = '0;
    for (int k = 1; k <= 16; k++)
      if (d_rnd >= 15'(625 * k)) q = q + 5'd1;
    frac    = q[3:0];
    int_inc = {1'b0, int_acc} + {{IW{1'b0}}, q[4]};
    int_c   = int_inc[IW-1:0];
    ovf_c   = ovf | int_inc[IW];
  end
`else
  always_comb begin
    frac = '0;
    for (int k = 1; k <= 15; k++)
      if (d_acc >= 14'(625 * k)) frac = frac + 4'd1;
    int_c = int_acc;
    ovf_c = ovf;
  end
`endif

  always_comb begin
    mag   = ovf_c ? '1 : {int_c, frac};
    fix_c = neg ? -{1'b0, mag} : {1'b0, mag};
    if (ovf_c && neg) fix_c = {1'b1, {MW{1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (take) begin
        if (is_minus || is_dig) state_nxt = S_INT;
        else if (is_dot)        state_nxt = S_FRAC;
        else if (!is_term)      state_nxt = S_ERR;
      end
      S_INT: if (take) begin
        if (is_dot)        state_nxt = S_FRAC;
        else if (is_term)  state_nxt = has_dig ? S_PAD : S_OUT;
        else if (!is_dig)  state_nxt = S_ERR;
      end
      S_FRAC: if (take) begin
        if (is_term)      state_nxt = !has_dig ? S_OUT : (n_cnt == 3'd4) ? S_CONV : S_PAD;
        else if (!is_dig) state_nxt = S_ERR;
      end
      S_ERR:  if (take && is_term) state_nxt = S_OUT;
      S_PAD:  if (n_cnt == 3'd3) state_nxt = S_CONV;
      S_CONV: state_nxt = S_OUT;
      S_OUT:  if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg     <= 1'b0;
      ovf     <= 1'b0;
      has_dig <= 1'b0;
      int_acc <= '0;
      d_acc   <= '0;
      n_cnt   <= '0;
      o_fix   <= '0;
      o_err   <= 1'b0;
      o_ovf   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_INT: if (take) begin
          if (is_dig) begin
            has_dig <= 1'b1;
            if (int_mul > {4'b0, {IW{1'b1}}}) begin
              ovf     <= 1'b1;
              int_acc <= '1;
            end else begin
              int_acc <= int_mul[IW-1:0];
            end
          end else if (is_minus && state == S_IDLE) begin
            neg <= 1'b1;
          end
        end
        S_FRAC: if (take && is_dig) begin
          has_dig <= 1'b1;
          if (n_cnt < 3'd4) begin
            d_acc <= d_mul + {10'd0, dig};
            n_cnt <= n_cnt + 3'd1;
          end
        end
        S_PAD: begin
          d_acc <= d_mul;
          n_cnt <= n_cnt + 3'd1;
        end
        S_CONV: begin
          o_fix   <= fix_c;
          o_ovf   <= ovf_c;
          o_err   <= 1'b0;
          o_valid <= 1'b1;
        end
        S_OUT: if (i_ready) begin
          o_valid <= 1'b0;
          neg     <= 1'b0;
          ovf     <= 1'b0;
          has_dig <= 1'b0;
          int_acc <= '0;
          d_acc   <= '0;
          n_cnt   <= '0;
        end
        default: ;
      endcase
      // direct jumps to OUT from the parse states are always syntax errors
      if (state_nxt == S_OUT && (state inside {S_INT, S_FRAC, S_ERR})) begin
        o_fix   <= '0;
        o_err   <= 1'b1;
        o_ovf   <= 1'b0;
        o_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ascii_to_fix.sv
// Directed bench for ascii_to_fix (INT_W=12): values, latency, errors, back-pressure, reset.
module tb_ascii_to_fix;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_ready, o_err, o_ovf, o_valid;
  logic [15:0] o_fix;
  int          errors = 0;
  int          checks = 0;
  int          lat;

  ascii_to_fix #(.INT_W(12)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_fix(o_fix), .o_err(o_err), .o_ovf(o_ovf), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int g = 0;
    @(negedge clk);
    i_data  = c;
    i_valid = 1'b1;
    while (!o_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("send/ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // edges after the terminator's accept edge before o_valid is seen
  task automatic wait_valid(output int l);
    l = 0;
    @(negedge clk);
    while (!o_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic expect_result(input string tag, input int exp_lat, input logic [15:0] fx,
                               input logic er, input logic ov);
    wait_valid(lat);
    chk({tag, "/valid"}, 32'(o_valid), 32'd1);
    chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/fix"}, 32'(o_fix), 32'(fx));
    chk({tag, "/err"}, 32'(o_err), 32'(er));
    chk({tag, "/ovf"}, 32'(o_ovf), 32'(ov));
  endtask

  task automatic accept(input string tag);
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    @(negedge clk);
    chk({tag, "/drop"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst/ready", 32'(o_ready), 32'd0);
    chk("rst/valid", 32'(o_valid), 32'd0);
    chk("rst/fix",   32'(o_fix),   32'd0);
    chk("rst/err",   32'(o_err),   32'd0);
    chk("rst/ovf",   32'(o_ovf),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle/ready", 32'(o_ready), 32'd1);

    send_str("3.5\015");        expect_result("t3.5", 4, 16'h0038, 1'b0, 1'b0); accept("t3.5");
    send_str("-1.0625 ");       expect_result("tn1.0625", 1, 16'hFFEF, 1'b0, 1'b0); accept("tn1.0625");
    send_str("12.99999\n");
`ifdef ASCII_TO_FIX_ROUND_EN
    expect_result("t12.99999", 1, 16'h00D0, 1'b0, 1'b0);
`else
    expect_result("t12.99999", 1, 16'h00CF, 1'b0, 1'b0);
`endif
    accept("t12.99999");
    send_str("5000\015");       expect_result("t5000", 5, 16'h7FFF, 1'b0, 1'b1); accept("t5000");
    send_str("-5000\015");      expect_result("tn5000", 5, 16'h8000, 1'b0, 1'b1); accept("tn5000");
    send_str("2047.9375\015");  expect_result("tmax", 1, 16'h7FFF, 1'b0, 1'b0); accept("tmax");
    send_str("2048\015");       expect_result("t2048", 5, 16'h7FFF, 1'b0, 1'b1); accept("t2048");
    send_str("1.2.3\015");      expect_result("tdot2", 0, 16'h0000, 1'b1, 1'b0); accept("tdot2");
    send_str("4a\015");         expect_result("t4a", 0, 16'h0000, 1'b1, 1'b0); accept("t4a");
    send_str("-\015");          expect_result("tminus", 0, 16'h0000, 1'b1, 1'b0); accept("tminus");

    send_str("\015\015");
    repeat (8) @(negedge clk);
    chk("empty/valid", 32'(o_valid), 32'd0);
    send_str("7\015");          expect_result("t7", 5, 16'h0070, 1'b0, 1'b0); accept("t7");
    repeat (8) @(negedge clk);
    chk("t7/no_dup", 32'(o_valid), 32'd0);

    send_str("-0.0\015");       expect_result("tneg0", 4, 16'h0000, 1'b0, 1'b0); accept("tneg0");
    send_str(".5\015");         expect_result("tdot5", 4, 16'h0008, 1'b0, 1'b0); accept("tdot5");

    send_str("-2.5\015");       expect_result("tbp", 4, 16'hFFD8, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp/fix",   32'(o_fix),   32'hFFD8);
      chk("bp/valid", 32'(o_valid), 32'd1);
      chk("bp/ready", 32'(o_ready), 32'd0);
    end
    accept("tbp");

    send_str("12.");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst/ready", 32'(o_ready), 32'd0);
    chk("mrst/valid", 32'(o_valid), 32'd0);
    chk("mrst/fix",   32'(o_fix),   32'd0);
    chk("mrst/err",   32'(o_err),   32'd0);
    chk("mrst/ovf",   32'(o_ovf),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_str("2\015");          expect_result("t2", 5, 16'h0020, 1'b0, 1'b0); accept("t2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
